// File: rtl/universal_register.sv
// N-bit datapath register with op-code selected load, shift, rotate and up/down count.
// Q and sout are registered on rising clk; zero is decoded combinationally from Q.
module universal_register #(
  parameter int              N       = 4,
  parameter logic [N-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] D,
  input  logic         sin_l,
  input  logic         sin_r,
  output logic [N-1:0] Q,
  output logic         sout,
  output logic         zero
);

  localparam logic [N-1:0] ZERO_V = {N{1'b0}};
  localparam logic [N-1:0] ONES_V = {N{1'b1}};
  localparam logic [N-1:0] ONE_V  = {{(N-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_DEC  = 3'b111;

  logic [N-1:0] q_r;
  logic         sout_r;
  logic [N-1:0] q_next_s;
  logic         sout_next_s;

  // Next-state decode for the selected operation; carry/borrow never reaches Q.
  always_comb begin
    q_next_s    = q_r;
    sout_next_s = 1'b0;
    case (mode)
      OP_HOLD: begin
        q_next_s    = q_r;
        sout_next_s = 1'b0;
      end
      OP_LOAD: begin
        q_next_s    = D;
        sout_next_s = 1'b0;
      end
      OP_SHL: begin
        q_next_s    = {q_r[N-2:0], sin_r};
        sout_next_s = q_r[N-1];
      end
      OP_SHR: begin
        q_next_s    = {sin_l, q_r[N-1:1]};
        sout_next_s = q_r[0];
      end
      OP_ROL: begin
        q_next_s    = {q_r[N-2:0], q_r[N-1]};
        sout_next_s = q_r[N-1];
      end
      OP_ROR: begin
        q_next_s    = {q_r[0], q_r[N-1:1]};
        sout_next_s = q_r[0];
      end
      OP_INC: begin
        q_next_s    = q_r + ONE_V;
        sout_next_s = (q_r == ONES_V);
      end
      OP_DEC: begin
        q_next_s    = q_r - ONE_V;
        sout_next_s = (q_r == ZERO_V);
      end
      default: begin
        q_next_s    = q_r;
        sout_next_s = 1'b0;
      end
    endcase
  end

  // State register: reset wins over enable; en=0 holds both Q and sout.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= RST_VAL;
      sout_r <= 1'b0;
    end else if (en) begin
      q_r    <= q_next_s;
      sout_r <= sout_next_s;
    end else begin
      q_r    <= q_r;
      sout_r <= sout_r;
    end
  end

  assign Q    = q_r;
  assign sout = sout_r;
  assign zero = (q_r == ZERO_V);

endmodule
